// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Brief    : Sequential shift-add-3 binary to packed BCD converter, one input
//            bit per clock. Optional leading-zero mask: define LEAD_BLANK_EN.
// Revision : 1.0  initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 6
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef logic [BIN_W+4:0] wide_t;
  typedef logic [BIN_W:0]   pow_t;

  // 10^DIGITS clamped to 2^BIN_W: anything at or above that cannot be reached
  // by bin, so the clamp never changes the overflow decision.
  function automatic pow_t pow10_sat();
    wide_t p;
    wide_t lim;
    lim = wide_t'(1) << BIN_W;
    p   = wide_t'(1);
    for (int i = 0; i < DIGITS; i++) begin
      p = p * wide_t'(10);
      if (p >= lim) p = lim;
    end
    return pow_t'(p);
  endfunction

  localparam pow_t c_pow10 = pow10_sat();

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [BIN_W-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_q;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_overflow;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W-1:0]   w_scratch_next;
  logic [BIN_W-1:0]   w_shift_next;
  logic               w_last;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                (r_scratch[4*gi +: 4] + 4'd3) :
                                r_scratch[4*gi +: 4];
    end
  endgenerate

  // The bit leaving the top digit is dropped by the truncating cast, which
  // yields bin mod 10^DIGITS.
  assign w_scratch_next = BCD_W'({w_adj, r_shift[BIN_W-1]});
  assign w_shift_next   = r_shift << 1;
  assign w_last         = (r_cnt == CNT_W'(1));

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_SHIFT;
      S_SHIFT: if (w_last) w_state_next = S_DONE;
      S_DONE:              w_state_next = S_IDLE;
      default:             w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
      r_ovf_q    <= 1'b0;
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift   <= bin;
            r_scratch <= '0;
            r_cnt     <= CNT_W'(BIN_W);
            r_ovf_q   <= ({1'b0, bin} >= c_pow10);
          end
        end
        S_SHIFT: begin
          r_shift   <= w_shift_next;
          r_scratch <= w_scratch_next;
          r_cnt     <= r_cnt - CNT_W'(1);
          // Results are published on the final shift so they are already
          // valid in the cycle done is high.
          if (w_last) begin
            r_bcd      <= w_scratch_next;
            r_overflow <= r_ovf_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign bcd      = r_bcd;
  assign overflow = r_overflow;

`ifdef LEAD_BLANK_EN
  logic [DIGITS-1:0] w_blank_next;
  logic [DIGITS-1:0] r_blank;

  always_comb begin
    logic w_run;
    w_run        = 1'b1;
    w_blank_next = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      w_run           = w_run & (w_scratch_next[4*i +: 4] == 4'd0);
      w_blank_next[i] = w_run;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_blank <= '0;
    end else if ((r_state == S_SHIFT) && w_last) begin
      r_blank <= w_blank_next;
    end
  end

  assign blank = r_blank;
`else
  assign blank = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Brief    : Scoreboard bench for bin2bcd_seq (latency, results, busy rules).
// Revision : 1.0  initial release
// ============================================================================
module tb_bin2bcd_seq;

  localparam int BIN_W  = 20;
  localparam int DIGITS = 6;
  localparam int LAT    = 20;

  logic          CLOCK_50 = 1'b0;
  logic          rst_n    = 1'b0;
  logic          start    = 1'b0;
  logic [19:0]   bin      = '0;
  logic          busy;
  logic          done;
  logic [23:0]   bcd;
  logic          overflow;
  logic [5:0]    blank;

  typedef struct packed {
    logic [19:0] src;
    logic [23:0] bcd;
    logic        ovf;
    logic [5:0]  blank;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .bcd      (bcd),
    .overflow (overflow),
    .blank    (blank)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic exp_t model(logic [19:0] v);
    exp_t e;
    int   x;
    logic run;
    e.src   = v;
    e.ovf   = (int'(v) >= 1000000);
    x       = int'(v) % 1000000;
    e.bcd   = '0;
    for (int i = 0; i < 6; i++) begin
      e.bcd[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    e.blank = '0;
    run     = 1'b1;
`ifdef LEAD_BLANK_EN
    for (int i = 5; i >= 1; i--) begin
      run        = run && (e.bcd[4*i +: 4] == 4'd0);
      e.blank[i] = run;
    end
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive_start(input logic [19:0] v);
    bin   = v;
    start = 1'b1;
    sb_q.push_back(model(v));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0)   $display("FAIL reset_busy got=%b exp=0", busy);         else n_pass++;
    n_checks++; if (done !== 1'b0)   $display("FAIL reset_done got=%b exp=0", done);         else n_pass++;
    n_checks++; if (bcd !== 24'h0)   $display("FAIL reset_bcd got=%h exp=000000", bcd);      else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", overflow);    else n_pass++;
    n_checks++; if (blank !== 6'h0)  $display("FAIL reset_blank got=%b exp=000000", blank);  else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_values();
    int          vals [14] = '{0, 999999, 1000000, 1048575, 105, 832040, 1, 9, 10,
                               99999, 123456, 0, 0, 0};
    exp_t        e;
    logic [23:0] prev;
    int          lat;
    bit          busy_ok;
    bit          stable;
    for (int i = 11; i < 14; i++) vals[i] = int'($urandom_range(0, 1048575));
    for (int i = 0; i < 14; i++) begin
      prev = bcd;
      drive_start(20'(vals[i]));
      tick();
      start   = 1'b0;
      bin     = 20'($urandom_range(0, 1048575));
      lat     = 0;
      busy_ok = 1'b1;
      stable  = 1'b1;
      while (!done && lat < 60) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (bcd !== prev)  stable  = 1'b0;
        tick();
        lat++;
      end
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      n_checks++; if (lat != LAT)  $display("FAIL latency bin=%0d got=%0d exp=%0d", e.src, lat, LAT); else n_pass++;
      n_checks++; if (bcd !== e.bcd) $display("FAIL bcd bin=%0d got=%h exp=%h", e.src, bcd, e.bcd); else n_pass++;
      n_checks++; if (overflow !== e.ovf) $display("FAIL overflow bin=%0d got=%b exp=%b", e.src, overflow, e.ovf); else n_pass++;
      n_checks++; if (blank !== e.blank) $display("FAIL blank bin=%0d got=%b exp=%b", e.src, blank, e.blank); else n_pass++;
      n_checks++; if (!busy_ok || busy !== 1'b1) $display("FAIL busy_window bin=%0d got=%b exp=1", e.src, busy_ok & busy); else n_pass++;
      n_checks++; if (!stable) $display("FAIL bcd_stable bin=%0d got=changed exp=held %h", e.src, prev); else n_pass++;
      tick();
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL done_one_cycle bin=%0d got done=%b busy=%b exp=0/0", e.src, done, busy); else n_pass++;
    end
  endtask

  task automatic test_ignore_busy();
    exp_t        e;
    int          n_done = 0;
    logic [23:0] got    = '0;
    logic        got_ovf = 1'b0;
    drive_start(20'd832040);
    tick();
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    bin   = 20'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (done === 1'b1) begin
        n_done++;
        got     = bcd;
        got_ovf = overflow;
      end
      tick();
    end
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_checks++; if (n_done != 1) $display("FAIL ignore_done_count got=%0d exp=1", n_done); else n_pass++;
    n_checks++; if (got !== e.bcd) $display("FAIL ignore_bcd got=%h exp=%h", got, e.bcd); else n_pass++;
    n_checks++; if (got_ovf !== e.ovf) $display("FAIL ignore_ovf got=%b exp=%b", got_ovf, e.ovf); else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   n_done = 0;
    int   lat    = 0;
    drive_start(20'd123457);
    tick();
    start = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    rst_n = 1'b0;
    #1;
    void'(sb_q.pop_back());
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (bcd !== 24'h0) $display("FAIL midrst_bcd got=%h exp=000000", bcd); else n_pass++;
    n_checks++; if (overflow !== 1'b0 || blank !== 6'h0) $display("FAIL midrst_flags got ovf=%b blank=%b exp=0/000000", overflow, blank); else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    n_checks++; if (n_done != 0) $display("FAIL midrst_no_done got=%0d exp=0", n_done); else n_pass++;
    drive_start(20'd654321);
    tick();
    start = 1'b0;
    while (!done && lat < 60) begin
      tick();
      lat++;
    end
    e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_checks++; if (lat != LAT) $display("FAIL midrst_latency got=%0d exp=%0d", lat, LAT); else n_pass++;
    n_checks++; if (bcd !== e.bcd) $display("FAIL midrst_bcd_after got=%h exp=%h", bcd, e.bcd); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    int   vals [4] = '{314159, 271828, 1048575, 42};
    exp_t e;
    int   lat;
    int   exp_lat;
    drive_start(20'(vals[0]));
    tick();
    for (int i = 0; i < 4; i++) begin
      lat     = 0;
      exp_lat = (i == 0) ? LAT : LAT + 1;
      if (i > 0) begin
        n_checks++; if (busy !== 1'b0) $display("FAIL b2b_gap_idle idx=%0d got=%b exp=0", i, busy); else n_pass++;
      end
      while (!done && lat < 60) begin
        tick();
        lat++;
      end
      e = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      n_checks++; if (lat != exp_lat) $display("FAIL b2b_latency idx=%0d got=%0d exp=%0d", i, lat, exp_lat); else n_pass++;
      n_checks++; if (bcd !== e.bcd) $display("FAIL b2b_bcd idx=%0d got=%h exp=%h", i, bcd, e.bcd); else n_pass++;
      n_checks++; if (overflow !== e.ovf) $display("FAIL b2b_ovf idx=%0d got=%b exp=%b", i, overflow, e.ovf); else n_pass++;
      if (i < 3) drive_start(20'(vals[i+1]));
      else start = 1'b0;
      tick();
    end
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL b2b_stop got=%b exp=0", busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_values();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
